control_sequencer: RTL and testbench

Synthesizable, one-state-per-clock successor to the mini CPU control unit. It decodes IR, sequences the datapath control strobes, and waits on a memory-ready handshake for every read and write. It also sequences BAout/Cout addressing, conditional PC load from Con_FF, Stop/halt, illegal-opcode trapping and an instruction counter. It sits between the IR and the datapath/memory interface. All delays are expressed in clock cycles, with no `#` timing.

---
 rtl/cu_pkg.sv | 76 +++++++
 rtl/cu_decode.sv | 41 ++++
 rtl/control_sequencer.sv | 170 +++++++++++++++++
 tb/tb_control_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the control sequencer: 6-bit state codes, opcodes, instruction classes.
package cu_pkg;

    localparam int unsigned ST_W = 6;
    localparam int unsigned OP_W = 5;

    localparam logic [ST_W-1:0] S_RESET = 6'd0;
    localparam logic [ST_W-1:0] S_T0    = 6'd1;
    localparam logic [ST_W-1:0] S_T1    = 6'd2;
    localparam logic [ST_W-1:0] S_T2    = 6'd3;
    localparam logic [ST_W-1:0] S_T3    = 6'd4;
    localparam logic [ST_W-1:0] S_ALU1  = 6'd5;
    localparam logic [ST_W-1:0] S_ALU2  = 6'd6;
    localparam logic [ST_W-1:0] S_ALU3  = 6'd7;
    localparam logic [ST_W-1:0] S_IMM1  = 6'd8;
    localparam logic [ST_W-1:0] S_IMM2  = 6'd9;
    localparam logic [ST_W-1:0] S_IMM3  = 6'd10;
    localparam logic [ST_W-1:0] S_MD1   = 6'd11;
    localparam logic [ST_W-1:0] S_MD2   = 6'd12;
    localparam logic [ST_W-1:0] S_MD3   = 6'd13;
    localparam logic [ST_W-1:0] S_MD4   = 6'd14;
    localparam logic [ST_W-1:0] S_NEG1  = 6'd15;
    localparam logic [ST_W-1:0] S_NEG2  = 6'd16;
    localparam logic [ST_W-1:0] S_LD1   = 6'd17;
    localparam logic [ST_W-1:0] S_LD2   = 6'd18;
    localparam logic [ST_W-1:0] S_LD3   = 6'd19;
    localparam logic [ST_W-1:0] S_LD4   = 6'd20;
    localparam logic [ST_W-1:0] S_LD5   = 6'd21;
    localparam logic [ST_W-1:0] S_LDI1  = 6'd22;
    localparam logic [ST_W-1:0] S_LDI2  = 6'd23;
    localparam logic [ST_W-1:0] S_LDI3  = 6'd24;
    localparam logic [ST_W-1:0] S_ST1   = 6'd25;
    localparam logic [ST_W-1:0] S_ST2   = 6'd26;
    localparam logic [ST_W-1:0] S_ST3   = 6'd27;
    localparam logic [ST_W-1:0] S_ST4   = 6'd28;
    localparam logic [ST_W-1:0] S_ST5   = 6'd29;
    localparam logic [ST_W-1:0] S_BR1   = 6'd30;
    localparam logic [ST_W-1:0] S_BR2   = 6'd31;
    localparam logic [ST_W-1:0] S_BR3   = 6'd32;
    localparam logic [ST_W-1:0] S_BR4   = 6'd33;
    localparam logic [ST_W-1:0] S_JR1   = 6'd34;
    localparam logic [ST_W-1:0] S_JAL1  = 6'd35;
    localparam logic [ST_W-1:0] S_JAL2  = 6'd36;
    localparam logic [ST_W-1:0] S_IN1   = 6'd37;
    localparam logic [ST_W-1:0] S_OUT1  = 6'd38;
    localparam logic [ST_W-1:0] S_MFHI1 = 6'd39;
    localparam logic [ST_W-1:0] S_MFLO1 = 6'd40;
    localparam logic [ST_W-1:0] S_HALT  = 6'd41;

    localparam logic [OP_W-1:0] OP_LD     = 5'd0;
    localparam logic [OP_W-1:0] OP_LDI    = 5'd1;
    localparam logic [OP_W-1:0] OP_ST     = 5'd2;
    localparam logic [OP_W-1:0] OP_ALU_LO = 5'd3;
    localparam logic [OP_W-1:0] OP_ALU_HI = 5'd11;
    localparam logic [OP_W-1:0] OP_IMM_LO = 5'd12;
    localparam logic [OP_W-1:0] OP_IMM_HI = 5'd14;
    localparam logic [OP_W-1:0] OP_MUL    = 5'd15;
    localparam logic [OP_W-1:0] OP_DIV    = 5'd16;
    localparam logic [OP_W-1:0] OP_NEG    = 5'd17;
    localparam logic [OP_W-1:0] OP_NOT    = 5'd18;
    localparam logic [OP_W-1:0] OP_BR     = 5'd19;
    localparam logic [OP_W-1:0] OP_JR     = 5'd20;
    localparam logic [OP_W-1:0] OP_JAL    = 5'd21;
    localparam logic [OP_W-1:0] OP_IN     = 5'd22;
    localparam logic [OP_W-1:0] OP_OUT    = 5'd23;
    localparam logic [OP_W-1:0] OP_MFHI   = 5'd24;
    localparam logic [OP_W-1:0] OP_MFLO   = 5'd25;
    localparam logic [OP_W-1:0] OP_NOP    = 5'd26;
    localparam logic [OP_W-1:0] OP_HALT   = 5'd27;

    typedef enum logic [4:0] {
        CLS_ALU, CLS_IMM, CLS_MD, CLS_NEG, CLS_LD, CLS_LDI, CLS_ST, CLS_BR,
        CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILL
    } instr_cls_e;

endpackage

// File: rtl/cu_decode.sv
// Opcode-to-class decoder; anything outside the defined set is flagged illegal.
module cu_decode
    import cu_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output instr_cls_e      cls,
    output logic            illegal
);

    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            OP_LD:          cls = CLS_LD;
            OP_LDI:         cls = CLS_LDI;
            OP_ST:          cls = CLS_ST;
            OP_MUL, OP_DIV: cls = CLS_MD;
            OP_NEG, OP_NOT: cls = CLS_NEG;
            OP_BR:          cls = CLS_BR;
            OP_JR:          cls = CLS_JR;
            OP_JAL:         cls = CLS_JAL;
            OP_IN:          cls = CLS_IN;
            OP_OUT:         cls = CLS_OUT;
            OP_MFHI:        cls = CLS_MFHI;
            OP_MFLO:        cls = CLS_MFLO;
            OP_NOP:         cls = CLS_NOP;
            OP_HALT:        cls = CLS_HALT;
            default: begin
                if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
                    cls = CLS_ALU;
                end else if (opcode >= OP_IMM_LO && opcode <= OP_IMM_HI) begin
                    cls = CLS_IMM;
                end else begin
                    cls = CLS_ILL;
                end
            end
        endcase
    end

    assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/control_sequencer.sv
// One-state-per-clock Moore control sequencer: fetch, per-class execute, memory handshake waits, halt.
module control_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned IW     = 32,
    parameter int unsigned MEM_HS = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [IW-1:0]     IR,
    input  logic              Con_FF,
    input  logic              Stop,
    input  logic              Mem_ready,
    output logic [ST_W-1:0]   present_state,
    output logic              Run,
    output logic              Illegal,
    output logic [CNT_W-1:0]  Instr_count,
    output logic              clear, IncPC, strobe, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic              PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout,
    output logic              PCin, IRin, Yin, Zlowin, Zhighin, MARin, MDRin, HIin, LOin,
    output logic              CONin, OutPortIn,
    output logic              Read, Write
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;
    instr_cls_e       dec_cls;
    logic             dec_illegal;
    logic             mem_wait;
    logic [ST_W-1:0]  end_nxt;
    logic             zin;
    logic             unused_ir;

    cu_decode u_decode (
        .opcode  (IR[IW-1 -: OP_W]),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    assign unused_ir = ^IR[IW-OP_W-1:0];
    assign mem_wait  = (MEM_HS != 0) && !Mem_ready;
    assign end_nxt   = Stop ? S_HALT : S_T0;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_RESET;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2: begin
                if (!mem_wait) begin
                    state_d = S_T3;
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_T3: begin
                case (dec_cls)
                    CLS_ALU:  state_d = S_ALU1;
                    CLS_IMM:  state_d = S_IMM1;
                    CLS_MD:   state_d = S_MD1;
                    CLS_NEG:  state_d = S_NEG1;
                    CLS_LD:   state_d = S_LD1;
                    CLS_LDI:  state_d = S_LDI1;
                    CLS_ST:   state_d = S_ST1;
                    CLS_BR:   state_d = S_BR1;
                    CLS_JR:   state_d = S_JR1;
                    CLS_JAL:  state_d = S_JAL1;
                    CLS_IN:   state_d = S_IN1;
                    CLS_OUT:  state_d = S_OUT1;
                    CLS_MFHI: state_d = S_MFHI1;
                    CLS_MFLO: state_d = S_MFLO1;
                    CLS_NOP:  state_d = end_nxt;
                    default:  state_d = S_HALT;
                endcase
                illegal_d = illegal_q | dec_illegal;
            end
            S_ALU1: state_d = S_ALU2;
            S_ALU2: state_d = S_ALU3;
            S_IMM1: state_d = S_IMM2;
            S_IMM2: state_d = S_IMM3;
            S_MD1:  state_d = S_MD2;
            S_MD2:  state_d = S_MD3;
            S_MD3:  state_d = S_MD4;
            S_NEG1: state_d = S_NEG2;
            S_LD1:  state_d = S_LD2;
            S_LD2:  state_d = S_LD3;
            S_LD3:  state_d = S_LD4;
            S_LD4:  state_d = mem_wait ? S_LD4 : S_LD5;
            S_LDI1: state_d = S_LDI2;
            S_LDI2: state_d = S_LDI3;
            S_ST1:  state_d = S_ST2;
            S_ST2:  state_d = S_ST3;
            S_ST3:  state_d = S_ST4;
            S_ST4:  state_d = S_ST5;
            S_ST5:  state_d = mem_wait ? S_ST5 : end_nxt;
            S_BR1:  state_d = S_BR2;
            S_BR2:  state_d = S_BR3;
            S_BR3:  state_d = S_BR4;
            S_JAL1: state_d = S_JAL2;
            S_ALU3, S_IMM3, S_MD4, S_NEG2, S_LD5, S_LDI3, S_BR4,
            S_JR1, S_JAL2, S_IN1, S_OUT1, S_MFHI1, S_MFLO1: state_d = end_nxt;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // Moore decode; the br final state is the one place an input (Con_FF) reaches an output.
    always_comb begin
        clear = 1'b0; IncPC = 1'b0; strobe = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; HIout = 1'b0;
        LOout = 1'b0; InPortout = 1'b0;
        PCin = 1'b0; IRin = 1'b0; Yin = 1'b0; zin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; CONin = 1'b0; OutPortIn = 1'b0;
        Read = 1'b0; Write = 1'b0;
        Run = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_RESET: clear = 1'b1;
            S_T0:    begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; zin = 1'b1; end
            S_T1, S_BR4: begin Zlowout = 1'b1; PCin = (state_q == S_T1) ? 1'b1 : Con_FF; end
            S_T2, S_LD4: begin Read = 1'b1; MDRin = 1'b1; end
            S_T3:    begin MDRout = 1'b1; IRin = 1'b1; end
            S_ALU1, S_IMM1: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            S_ALU2:  begin Grc = 1'b1; Rout = 1'b1; zin = 1'b1; end
            S_IMM2, S_LD2, S_LDI2, S_ST2, S_BR3: begin Cout = 1'b1; zin = 1'b1; end
            S_ALU3, S_IMM3, S_NEG2, S_LDI3: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_MD1:   begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            S_MD2, S_NEG1: begin Grb = 1'b1; Rout = 1'b1; zin = 1'b1; end
            S_MD3:   begin Zhighout = 1'b1; HIin = 1'b1; end
            S_MD4:   begin Zlowout = 1'b1; LOin = 1'b1; end
            S_LD1, S_LDI1, S_ST1: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            S_LD3, S_ST3: begin Zlowout = 1'b1; MARin = 1'b1; end
            S_LD5:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_ST4:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            S_ST5:   Write = 1'b1;
            S_BR1:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            S_BR2:   begin PCout = 1'b1; Yin = 1'b1; end
            S_JR1, S_JAL2: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            S_JAL1:  PCout = 1'b1;
            S_IN1:   begin strobe = 1'b1; InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_OUT1:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
            S_MFHI1: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_MFLO1: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
        endcase
    end

    assign Zlowin        = zin;
    assign Zhighin       = zin;
    assign present_state = state_q;
    assign Illegal       = illegal_q;
    assign Instr_count   = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: drivers push expected per-instruction results, a monitor checks at each boundary.
module tb_control_sequencer;
    import cu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] IR = '0;
    logic        Con_FF = 1'b0, Stop = 1'b0, Mem_ready = 1'b1;

    logic [5:0]  present_state, u0_present_state;
    logic        Run, Illegal, u0_Run, u0_Illegal;
    logic [15:0] Instr_count, u0_Instr_count;
    logic clear, IncPC, strobe, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout;
    logic PCin, IRin, Yin, Zlowin, Zhighin, MARin, MDRin, HIin, LOin, CONin, OutPortIn;
    logic Read, Write;
    logic u0_clear, u0_IncPC, u0_strobe, u0_Gra, u0_Grb, u0_Grc, u0_Rin, u0_Rout, u0_BAout, u0_Cout;
    logic u0_PCout, u0_MDRout, u0_Zhighout, u0_Zlowout, u0_HIout, u0_LOout, u0_InPortout;
    logic u0_PCin, u0_IRin, u0_Yin, u0_Zlowin, u0_Zhighin, u0_MARin, u0_MDRin, u0_HIin, u0_LOin;
    logic u0_CONin, u0_OutPortIn, u0_Read, u0_Write;

    always #5 Clock = ~Clock;

    control_sequencer #(.IW(32), .MEM_HS(1), .CNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Con_FF(Con_FF), .Stop(Stop), .Mem_ready(Mem_ready),
        .present_state(present_state), .Run(Run), .Illegal(Illegal), .Instr_count(Instr_count),
        .clear(clear), .IncPC(IncPC), .strobe(strobe), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout),
        .LOout(LOout), .InPortout(InPortout),
        .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .MARin(MARin),
        .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortIn(OutPortIn),
        .Read(Read), .Write(Write)
    );

    // Single-cycle-memory variant with Mem_ready tied low.
    control_sequencer #(.IW(32), .MEM_HS(0), .CNT_W(16)) dut0 (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Con_FF(Con_FF), .Stop(1'b0), .Mem_ready(1'b0),
        .present_state(u0_present_state), .Run(u0_Run), .Illegal(u0_Illegal), .Instr_count(u0_Instr_count),
        .clear(u0_clear), .IncPC(u0_IncPC), .strobe(u0_strobe), .Gra(u0_Gra), .Grb(u0_Grb), .Grc(u0_Grc),
        .Rin(u0_Rin), .Rout(u0_Rout), .BAout(u0_BAout), .Cout(u0_Cout),
        .PCout(u0_PCout), .MDRout(u0_MDRout), .Zhighout(u0_Zhighout), .Zlowout(u0_Zlowout),
        .HIout(u0_HIout), .LOout(u0_LOout), .InPortout(u0_InPortout),
        .PCin(u0_PCin), .IRin(u0_IRin), .Yin(u0_Yin), .Zlowin(u0_Zlowin), .Zhighin(u0_Zhighin),
        .MARin(u0_MARin), .MDRin(u0_MDRin), .HIin(u0_HIin), .LOin(u0_LOin), .CONin(u0_CONin),
        .OutPortIn(u0_OutPortIn), .Read(u0_Read), .Write(u0_Write)
    );

    typedef struct {
        logic [5:0] st;
        int lat, cnt, rd, wr, pc, rin, rin_at, hi, lo, ill;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0, n_bad = 0;
    logic [5:0] exp_seq [9] = '{S_T0, S_T1, S_T2, S_T3, S_T0, S_T1, S_T2, S_T3, S_T0};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ir_of(input int op);
        ir_of = (32'(op) << 27) | 32'h0001_2345;
    endfunction

    task automatic wait_st(input logic [5:0] s);
        for (int i = 0; i < 200; i++) begin
            @(posedge Clock); #1;
            if (present_state == s) return;
        end
        n_vec++; n_bad++;
        $display("FAIL wait_state: timeout, got state %0d expected %0d", present_state, s);
    endtask

    task automatic do_reset(input logic [31:0] ir0, input logic mr0);
        @(posedge Clock); #1;
        Reset = 1'b0; Stop = 1'b0; Con_FF = 1'b0; Mem_ready = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_state", 32'(present_state), 32'(S_RESET));
        check("rst_run", 32'(Run), 0);
        check("rst_illegal", 32'(Illegal), 0);
        check("rst_count", 32'(Instr_count), 0);
        check("rst_clear", 32'(clear), 1);
        check("rst_others", 32'({IncPC, strobe, Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, MDRout,
                                 Zhighout, Zlowout, HIout, LOout, InPortout, PCin, IRin, Yin, Zlowin,
                                 Zhighin, MARin, MDRin, HIin, LOin, CONin, OutPortIn, Read, Write}), 0);
        IR = ir0; Mem_ready = mr0;
        Reset = 1'b1;
    endtask

    // Set the opcode during this instruction's T1 and queue its expected boundary result.
    task automatic do_instr(input int op, input logic stp, input logic cf, input logic [5:0] st,
                            input int lat, input int cnt, input int rd, input int wr, input int pc,
                            input int rin, input int rin_at, input int hi, input int lo, input int ill);
        exp_t r;
        wait_st(S_T1);
        IR = ir_of(op); Stop = stp; Con_FF = cf;
        r.st = st; r.lat = lat; r.cnt = cnt; r.rd = rd; r.wr = wr; r.pc = pc;
        r.rin = rin; r.rin_at = rin_at; r.hi = hi; r.lo = lo; r.ill = ill;
        sb.push_back(r);
    endtask

    task automatic finish_halt();
        wait_st(S_HALT);
        repeat (2) @(posedge Clock);
    endtask

    // Monitor: accumulate strobes from each T0 entry and compare at the next T0 or HALT entry.
    logic [5:0] prev_st = S_RESET;
    bit in_instr = 0;
    int m_cyc, m_rd, m_wr, m_pc, m_rin, m_rin_at, m_hi, m_lo;

    always @(negedge Clock) begin
        if (!Reset) begin
            in_instr = 0;
            prev_st  = S_RESET;
        end else begin
            if (present_state != prev_st && (present_state == S_T0 || present_state == S_HALT)) begin
                if (in_instr) begin
                    if (sb.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL sb_unexpected: boundary state %0d with no expected entry", present_state);
                    end else begin
                        e = sb.pop_front();
                        check("end_state", 32'(present_state), 32'(e.st));
                        check("latency", m_cyc, e.lat);
                        check("instr_count", 32'(Instr_count), e.cnt);
                        check("illegal", 32'(Illegal), e.ill);
                        check("run", 32'(Run), (e.st == S_T0) ? 1 : 0);
                        check("read_cycles", m_rd, e.rd);
                        check("write_cycles", m_wr, e.wr);
                        check("pcin_cycles", m_pc, e.pc);
                        check("gra_rin_cycles", m_rin, e.rin);
                        check("gra_rin_at", m_rin_at, e.rin_at);
                        check("hiin_cycles", m_hi, e.hi);
                        check("loin_cycles", m_lo, e.lo);
                    end
                end
                in_instr = (present_state == S_T0);
                m_cyc = 0; m_rd = 0; m_wr = 0; m_pc = 0; m_rin = 0; m_rin_at = 0; m_hi = 0; m_lo = 0;
            end
            if (in_instr) begin
                m_cyc++;
                m_rd += int'(Read);
                m_wr += int'(Write);
                m_pc += int'(PCin);
                m_hi += int'(HIin);
                m_lo += int'(LOin);
                if (Gra && Rin) begin
                    m_rin++;
                    if (m_rin_at == 0) m_rin_at = m_cyc;
                end
            end
            prev_st = present_state;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Straight-line program through every class, ending on halt.
        do_reset(ir_of(3), 1'b1);
        //       op stp cf  end     lat cnt rd wr pc rin at hi lo ill
        do_instr( 3, 0, 0, S_T0,    7,  1, 1, 0, 1, 1, 7, 0, 0, 0);
        do_instr(12, 0, 0, S_T0,    7,  2, 1, 0, 1, 1, 7, 0, 0, 0);
        do_instr(17, 0, 0, S_T0,    6,  3, 1, 0, 1, 1, 6, 0, 0, 0);
        do_instr(15, 0, 0, S_T0,    8,  4, 1, 0, 1, 0, 0, 1, 1, 0);
        do_instr(20, 0, 0, S_T0,    5,  5, 1, 0, 2, 0, 0, 0, 0, 0);
        do_instr(21, 0, 0, S_T0,    6,  6, 1, 0, 2, 0, 0, 0, 0, 0);
        do_instr(22, 0, 0, S_T0,    5,  7, 1, 0, 1, 1, 5, 0, 0, 0);
        do_instr(24, 0, 0, S_T0,    5,  8, 1, 0, 1, 1, 5, 0, 0, 0);
        do_instr( 1, 0, 0, S_T0,    7,  9, 1, 0, 1, 1, 7, 0, 0, 0);
        do_instr(26, 0, 0, S_T0,    4, 10, 1, 0, 1, 0, 0, 0, 0, 0);
        do_instr(16, 0, 0, S_T0,    8, 11, 1, 0, 1, 0, 0, 1, 1, 0);
        do_instr(18, 0, 0, S_T0,    6, 12, 1, 0, 1, 1, 6, 0, 0, 0);
        do_instr(25, 0, 0, S_T0,    5, 13, 1, 0, 1, 1, 5, 0, 0, 0);
        do_instr(23, 0, 0, S_T0,    5, 14, 1, 0, 1, 0, 0, 0, 0, 0);
        do_instr( 2, 0, 0, S_T0,    9, 15, 1, 1, 1, 0, 0, 0, 0, 0);
        do_instr( 0, 0, 0, S_T0,    9, 16, 2, 0, 1, 1, 9, 0, 0, 0);
        do_instr(27, 0, 0, S_HALT,  4, 17, 1, 0, 1, 0, 0, 0, 0, 0);
        finish_halt();

        // ld with three memory wait cycles in its read state.
        do_reset(ir_of(0), 1'b1);
        do_instr( 0, 0, 0, S_T0,   12,  1, 5, 0, 1, 1, 12, 0, 0, 0);
        wait_st(S_LD4);
        Mem_ready = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Mem_ready = 1'b1;
        do_instr(27, 0, 0, S_HALT,  4,  2, 1, 0, 1, 0, 0, 0, 0, 0);
        finish_halt();

        // br not taken, br taken, then nop with Stop.
        do_reset(ir_of(19), 1'b1);
        do_instr(19, 0, 0, S_T0,    8,  1, 1, 0, 1, 0, 0, 0, 0, 0);
        do_instr(19, 0, 1, S_T0,    8,  2, 1, 0, 2, 0, 0, 0, 0, 0);
        do_instr(26, 1, 0, S_HALT,  4,  3, 1, 0, 1, 0, 0, 0, 0, 0);
        finish_halt();

        // Illegal opcode: sticky flag and an absorbing HALT.
        do_reset(ir_of(30), 1'b1);
        do_instr(30, 0, 0, S_HALT,  4,  1, 1, 0, 1, 0, 0, 0, 0, 1);
        wait_st(S_HALT);
        for (int i = 0; i < 20; i++) begin
            Mem_ready = ~Mem_ready;
            Stop = ~Stop;
            @(posedge Clock); #1;
            check("halt_state", 32'(present_state), 32'(S_HALT));
            check("halt_run", 32'(Run), 0);
            check("halt_illegal", 32'(Illegal), 1);
        end

        // Stop raised mid-mul: instruction completes, then HALT.
        do_reset(ir_of(15), 1'b1);
        do_instr(15, 0, 0, S_HALT,  8,  1, 1, 0, 1, 0, 0, 1, 1, 0);
        wait_st(S_MD2);
        Stop = 1'b1;
        finish_halt();

        // Stop together with the halt opcode.
        do_reset(ir_of(27), 1'b1);
        do_instr(27, 1, 0, S_HALT,  4,  1, 1, 0, 1, 0, 0, 0, 0, 0);
        finish_halt();

        // Single-cycle memory variant runs nops with Mem_ready low; the handshake variant stalls.
        do_reset(ir_of(26), 1'b0);
        for (int k = 0; k < 9; k++) begin
            @(posedge Clock); #1;
            check("nohs_state", 32'(u0_present_state), 32'(exp_seq[k]));
        end
        check("nohs_count", 32'(u0_Instr_count), 2);
        check("hs_stall_state", 32'(present_state), 32'(S_T2));

        // Reset during the st write state drops Write at once.
        do_reset(ir_of(2), 1'b1);
        wait_st(S_ST4);
        Mem_ready = 1'b0;
        @(posedge Clock); #1;
        check("st_write_state", 32'(present_state), 32'(S_ST5));
        check("st_write_high", 32'(Write), 1);
        #2 Reset = 1'b0;
        #1;
        check("rst_write_low", 32'(Write), 0);
        check("rst_async_state", 32'(present_state), 32'(S_RESET));
        check("rst_async_clear", 32'(clear), 1);
        check("rst_async_count", 32'(Instr_count), 0);
        repeat (2) @(posedge Clock);

        check("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
